result_lane_serializer: RTL and testbench

- Downstream consumer of the packed multiply-accumulate result bus.
- Captures one N-lane result word, each lane W bits, and streams it out one lane per transfer on a valid/ready interface. Lane 0 (least-significant bits) goes first.
- Sits between the multiply/KSA datapath output and narrow downstream logic such as a FIFO, UART or bus bridge.
- Provides input back-pressure and a sticky flag for dropped frames.

---
 rtl/result_lane_serializer.sv | 109 ++++++++++
 tb/tb_result_lane_serializer.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/result_lane_serializer.sv
// rtl/result_lane_serializer.sv - captures an N-lane packed result word and streams it one lane per transfer
module result_lane_serializer #(
  parameter  int N  = 4,
  parameter  int W  = 17,
  localparam int IW = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           y_valid,
  input  logic [N*W-1:0] y,
  output logic           y_ready,
  output logic           lane_valid,
  input  logic           lane_ready,
  output logic [W-1:0]   lane_data,
  output logic [IW-1:0]  lane_idx,
  output logic           lane_last,
  output logic           drop_err
);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

  state_t          state_q, state_d;
  logic [N*W-1:0]  hold_q, hold_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic            drop_q, drop_d;

  logic            idx_is_last;
  logic            lane_xfer;
  logic            accept;

  // The output side is a pure function of registered state, hold and index.
  assign lane_valid  = (state_q == SEND);
  assign lane_idx    = idx_q;
  assign drop_err    = drop_q;
  assign idx_is_last = (idx_q == LAST_IDX);
  assign lane_last   = lane_valid & idx_is_last;
  assign lane_xfer   = lane_valid & lane_ready;

  // Select the current lane out of the hold register; index values >= N never occur.
  always_comb begin
    lane_data = '0;
    for (int k = 0; k < N; k++) begin
      if (idx_q == IW'(k)) begin
        lane_data = hold_q[k*W +: W];
      end
    end
  end

  // Next-state logic: accept a word when idle or when the last lane leaves, otherwise walk the lanes.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    idx_d   = idx_q;
    y_ready = (state_q == IDLE) | (lane_xfer & idx_is_last);
    accept  = y_valid & y_ready;
    drop_d  = drop_q | (y_valid & ~y_ready);

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          hold_d  = y;
          idx_d   = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        if (lane_xfer) begin
          if (idx_is_last) begin
            // Back-to-back frames: a word offered alongside the last lane is taken with no bubble.
            idx_d = '0;
            if (accept) begin
              hold_d  = y;
              state_d = SEND;
            end else begin
              state_d = IDLE;
            end
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase
  end

  // State, hold, index and sticky drop registers; reset discards any frame in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      hold_q  <= '0;
      idx_q   <= '0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      idx_q   <= idx_d;
      drop_q  <= drop_d;
    end
  end

endmodule

// File: tb/tb_result_lane_serializer.sv
// tb/tb_result_lane_serializer.sv - directed self-checking bench for result_lane_serializer
module tb_result_lane_serializer;

  localparam int N  = 4;
  localparam int W  = 17;
  localparam int IW = $clog2(N);

  logic           clk;
  logic           rst;
  logic           y_valid;
  logic [N*W-1:0] y;
  logic           y_ready;
  logic           lane_valid;
  logic           lane_ready;
  logic [W-1:0]   lane_data;
  logic [IW-1:0]  lane_idx;
  logic           lane_last;
  logic           drop_err;

  int checks;
  int errors;

  localparam logic [N*W-1:0] FRAME_A = {17'h1FFFF, 17'h00000, 17'h0ABCD, 17'h00001};
  localparam logic [N*W-1:0] FRAME_B = {17'h04444, 17'h13333, 17'h02222, 17'h11111};
  localparam logic [N*W-1:0] FRAME_D = {17'h15555, 17'h15555, 17'h15555, 17'h15555};

  logic [W-1:0] exp_a [N];
  logic [W-1:0] exp_b [N];

  result_lane_serializer #(.N(N), .W(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .y_valid    (y_valid),
    .y          (y),
    .y_ready    (y_ready),
    .lane_valid (lane_valid),
    .lane_ready (lane_ready),
    .lane_data  (lane_data),
    .lane_idx   (lane_idx),
    .lane_last  (lane_last),
    .drop_err   (drop_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle, drive inputs just after the edge, then settle before checks.
  task automatic cyc(input logic vv, input logic [N*W-1:0] yy, input logic lr);
    @(posedge clk);
    #1;
    y_valid    = vv;
    y          = yy;
    lane_ready = lr;
    #2;
  endtask

  task automatic check_lane(input string tag, input logic [W-1:0] d, input int idx);
    check({tag, "_valid"}, 32'(lane_valid), 32'd1);
    check({tag, "_data"},  32'(lane_data),  32'(d));
    check({tag, "_idx"},   32'(lane_idx),   32'(idx));
    check({tag, "_last"},  32'(lane_last),  32'(idx == N - 1));
  endtask

  initial begin
    checks = 0;
    errors = 0;
    exp_a[0] = 17'h00001; exp_a[1] = 17'h0ABCD; exp_a[2] = 17'h00000; exp_a[3] = 17'h1FFFF;
    exp_b[0] = 17'h11111; exp_b[1] = 17'h02222; exp_b[2] = 17'h13333; exp_b[3] = 17'h04444;

    rst        = 1'b1;
    y_valid    = 1'b0;
    y          = '0;
    lane_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    #2;
    check("rst_lane_valid", 32'(lane_valid), 32'd0);
    check("rst_lane_data",  32'(lane_data),  32'd0);
    check("rst_lane_idx",   32'(lane_idx),   32'd0);
    check("rst_lane_last",  32'(lane_last),  32'd0);
    check("rst_drop_err",   32'(drop_err),   32'd0);
    check("rst_y_ready",    32'(y_ready),    32'd1);

    // Single frame with lane_ready held high.
    cyc(1'b1, FRAME_A, 1'b1);
    check("t1_accept_ready", 32'(y_ready), 32'd1);
    check("t1_accept_valid", 32'(lane_valid), 32'd0);
    for (int i = 0; i < N; i++) begin
      cyc(1'b0, '0, 1'b1);
      check_lane($sformatf("t1_lane%0d", i), exp_a[i], i);
      check($sformatf("t1_y_ready%0d", i), 32'(y_ready), 32'(i == N - 1));
    end
    cyc(1'b0, '0, 1'b1);
    check("t1_end_valid", 32'(lane_valid), 32'd0);
    check("t1_end_ready", 32'(y_ready), 32'd1);

    // Back-pressure on lane 1.
    cyc(1'b1, FRAME_A, 1'b1);
    cyc(1'b0, '0, 1'b1);
    check_lane("t2_lane0", exp_a[0], 0);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, '0, 1'b0);
      check_lane($sformatf("t2_stall%0d", i), exp_a[1], 1);
      check($sformatf("t2_stall_ready%0d", i), 32'(y_ready), 32'd0);
    end
    cyc(1'b0, '0, 1'b1);
    check_lane("t2_lane1", exp_a[1], 1);
    cyc(1'b0, '0, 1'b1);
    check_lane("t2_lane2", exp_a[2], 2);
    cyc(1'b0, '0, 1'b1);
    check_lane("t2_lane3", exp_a[3], 3);
    cyc(1'b0, '0, 1'b1);
    check("t2_end_valid", 32'(lane_valid), 32'd0);

    // Back-to-back frames: B offered on A's last lane.
    cyc(1'b1, FRAME_A, 1'b1);
    for (int i = 0; i < N - 1; i++) begin
      cyc(1'b0, '0, 1'b1);
      check_lane($sformatf("t3_a%0d", i), exp_a[i], i);
    end
    cyc(1'b1, FRAME_B, 1'b1);
    check_lane("t3_a3", exp_a[3], 3);
    check("t3_b_accept_ready", 32'(y_ready), 32'd1);
    for (int i = 0; i < N; i++) begin
      cyc(1'b0, '0, 1'b1);
      check_lane($sformatf("t3_b%0d", i), exp_b[i], i);
    end
    cyc(1'b0, '0, 1'b1);
    check("t3_end_valid", 32'(lane_valid), 32'd0);
    check("t3_drop_clear", 32'(drop_err), 32'd0);

    // Drop: word offered mid-frame is ignored and flagged.
    cyc(1'b1, FRAME_A, 1'b1);
    cyc(1'b0, '0, 1'b1);
    check_lane("t4_lane0", exp_a[0], 0);
    cyc(1'b1, FRAME_D, 1'b1);
    check_lane("t4_lane1", exp_a[1], 1);
    check("t4_offer_ready", 32'(y_ready), 32'd0);
    check("t4_drop_pre", 32'(drop_err), 32'd0);
    cyc(1'b0, '0, 1'b1);
    check_lane("t4_lane2", exp_a[2], 2);
    check("t4_drop_set", 32'(drop_err), 32'd1);
    cyc(1'b0, '0, 1'b1);
    check_lane("t4_lane3", exp_a[3], 3);
    cyc(1'b0, '0, 1'b1);
    check("t4_end_valid", 32'(lane_valid), 32'd0);
    check("t4_drop_sticky", 32'(drop_err), 32'd1);
    cyc(1'b0, '0, 1'b1);
    check("t4_no_ghost", 32'(lane_valid), 32'd0);

    // Reset in the middle of a frame.
    cyc(1'b1, FRAME_A, 1'b1);
    cyc(1'b0, '0, 1'b1);
    cyc(1'b0, '0, 1'b1);
    cyc(1'b0, '0, 1'b0);
    check_lane("t5_lane2", exp_a[2], 2);
    rst = 1'b1;
    #1;
    check("t5_async_valid", 32'(lane_valid), 32'd0);
    check("t5_async_idx",   32'(lane_idx),   32'd0);
    check("t5_async_drop",  32'(drop_err),   32'd0);
    check("t5_async_data",  32'(lane_data),  32'd0);
    @(posedge clk);
    #1;
    rst        = 1'b0;
    lane_ready = 1'b1;
    #2;
    check("t5_rel_ready", 32'(y_ready), 32'd1);
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, '0, 1'b1);
      check($sformatf("t5_no_stale%0d", i), 32'(lane_valid), 32'd0);
    end

    // Idle stability with lane_ready toggling.
    for (int i = 0; i < 20; i++) begin
      cyc(1'b0, '0, 1'(i % 2));
      check($sformatf("t6_valid%0d", i), 32'(lane_valid), 32'd0);
      check($sformatf("t6_ready%0d", i), 32'(y_ready),    32'd1);
      check($sformatf("t6_drop%0d", i),  32'(drop_err),   32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
